// File: rtl/sfpp_reconfig_master_0_rx_fifo_adt.sv
// Byte-stream timing adapter: a show-ahead FIFO between a source with no ready
// and a sink that can stall. Overflowing bytes are dropped and counted.
module sfpp_reconfig_master_0_rx_fifo_adt #(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 16,
  parameter int ALMOST_FULL    = 12,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          in_valid_i,
  input  logic [DATA_WIDTH-1:0]         in_data_i,
  output logic                          out_valid_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  input  logic                          out_ready_i,
  output logic [$clog2(DEPTH):0]        fill_level_o,
  output logic                          almost_full_o,
  output logic                          overflow_o,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count_o,
  input  logic                          clear_overflow_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);
  localparam logic [FW-1:0] AF_F    = FW'(ALMOST_FULL);

  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]             fill_q, fill_d;
  logic                      vld_q, af_q, ovf_q, ovf_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic                      full, pop, push, drop;

  // Full is judged from the count; pointers alone are ambiguous when equal.
  assign full = (fill_q == DEPTH_F);
  assign pop  = vld_q & out_ready_i;
  assign push = in_valid_i & (~full | pop);
  assign drop = in_valid_i & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      fill_d = fill_q + 1'b1;
    else if (pop && !push) fill_d = fill_q - 1'b1;
  end

  // A drop in the same cycle as a clear lands after the clear.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clear_overflow_i) begin
      ovf_d  = drop;
      drop_d = drop ? DROP_CNT_WIDTH'(1) : '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (!(&drop_q)) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      vld_q    <= 1'b0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      vld_q    <= (fill_d != '0);
      af_q     <= (fill_d >= AF_F);
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= in_data_i;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i && drop) $display("%m: byte 0x%0h dropped, FIFO full", in_data_i);
  end
`endif

  assign out_valid_o   = vld_q;
  assign out_data_o    = mem[rd_ptr_q];
  assign fill_level_o  = fill_q;
  assign almost_full_o = af_q;
  assign overflow_o    = ovf_q;
  assign drop_count_o  = drop_q;
endmodule

// File: tb/tb_sfpp_reconfig_master_0_rx_fifo_adt.sv
// Directed bench with a queue-based reference model compared every cycle.
module tb_sfpp_reconfig_master_0_rx_fifo_adt;
  localparam int DW = 8, DEPTH = 16, AFL = 12, CW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          clear_ovf = 1'b0;
  logic          out_valid, almost_full, overflow;
  logic [DW-1:0] out_data;
  logic [4:0]    fill_level;
  logic [CW-1:0] drop_count;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mq[$];
  logic          m_ovf = 1'b0;
  int            m_cnt = 0;

  sfpp_reconfig_master_0_rx_fifo_adt #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL(AFL), .DROP_CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .fill_level_o(fill_level), .almost_full_o(almost_full), .overflow_o(overflow),
    .drop_count_o(drop_count), .clear_overflow_i(clear_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a byte queue plus drop bookkeeping, advanced at each edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_ovf <= 1'b0;
      m_cnt <= 0;
    end else begin : model
      automatic bit pp = (mq.size() > 0) && out_ready;
      automatic bit dr = in_valid && (mq.size() == DEPTH) && !pp;
      if (pp) void'(mq.pop_front());
      if (in_valid && !dr) mq.push_back(in_data);
      if (clear_ovf) begin
        m_ovf <= dr;
        m_cnt <= dr ? 1 : 0;
      end else if (dr) begin
        m_ovf <= 1'b1;
        m_cnt <= (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("out_valid", int'(out_valid), int'(mq.size() != 0));
      chk("fill_level", int'(fill_level), mq.size());
      chk("almost_full", int'(almost_full), int'(mq.size() >= AFL));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("drop_count", int'(drop_count), m_cnt);
      if (mq.size() != 0) chk("out_data", int'(out_data), int'(mq[0]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] tail [16];

  initial begin
    repeat (2) cyc();
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst fill", int'(fill_level), 0);
    chk("rst almost_full", int'(almost_full), 0);
    chk("rst overflow", int'(overflow), 0);
    chk("rst drop_count", int'(drop_count), 0);
    reset_n = 1'b1;
    cyc();

    // Pass-through: each byte appears one cycle after it is offered.
    out_ready = 1'b1;
    chk("empty+in_valid no bypass", int'(out_valid), 0);
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      if (i == 1) begin #1 chk("no bypass same cycle", int'(out_valid), 0); end
      cyc();
      chk("pass data", int'(out_data), i);
      chk("pass fill", int'(fill_level), 1);
    end
    in_valid = 1'b0;
    cyc();
    chk("pass drained", int'(out_valid), 0);

    // Fill to the brim with the sink stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h10 + i);
      cyc();
      if (i == 10) chk("af after 11", int'(almost_full), 0);
      if (i == 11) chk("af after 12", int'(almost_full), 1);
    end
    chk("full fill", int'(fill_level), 16);
    chk("full no ovf", int'(overflow), 0);

    for (int i = 0; i < 3; i++) begin
      in_data = DW'(8'h30 + i);
      cyc();
    end
    in_valid = 1'b0;
    chk("3 drops ovf", int'(overflow), 1);
    chk("3 drops cnt", int'(drop_count), 3);
    chk("head kept", int'(out_data), 8'h10);
    clear_ovf = 1'b1;
    cyc();
    clear_ovf = 1'b0;
    chk("clear ovf", int'(overflow), 0);
    chk("clear cnt", int'(drop_count), 0);

    // Full with concurrent pop: accepted, no drop, pointers wrap.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h40 + i);
      cyc();
      chk("full+pop fill", int'(fill_level), 16);
    end
    in_valid = 1'b0;
    chk("full+pop no drop", int'(drop_count), 0);
    for (int i = 0; i < 6; i++) tail[i] = DW'(8'h1A + i);
    for (int i = 0; i < 10; i++) tail[6 + i] = DW'(8'h40 + i);
    for (int i = 0; i < 16; i++) begin
      chk("drain order", int'(out_data), int'(tail[i]));
      cyc();
    end
    chk("drain empty", int'(out_valid), 0);
    cyc();
    chk("ready while empty", int'(fill_level), 0);

    // Saturating drop counter, then a drop coinciding with clear.
    out_ready = 1'b0;
    for (int i = 0; i < 16 + 300; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h50 + i);
      cyc();
    end
    chk("sat cnt", int'(drop_count), 8'hFF);
    chk("sat ovf", int'(overflow), 1);
    clear_ovf = 1'b1;
    cyc();
    clear_ovf = 1'b0; in_valid = 1'b0;
    chk("clear+drop cnt", int'(drop_count), 1);
    chk("clear+drop ovf", int'(overflow), 1);

    // Async reset mid-burst.
    out_ready = 1'b1;
    repeat (16) cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h60 + i);
      cyc();
    end
    in_valid = 1'b0;
    chk("pre-reset fill", int'(fill_level), 7);
    #2 reset_n = 1'b0;
    #1;
    chk("async out_valid", int'(out_valid), 0);
    chk("async fill", int'(fill_level), 0);
    chk("async ovf", int'(overflow), 0);
    chk("async cnt", int'(drop_count), 0);
    cyc();
    reset_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    cyc();
    in_valid = 1'b0;
    chk("post-reset valid", int'(out_valid), 1);
    chk("post-reset data", int'(out_data), 8'hAA);
    chk("post-reset fill", int'(fill_level), 1);
    cyc();
    chk("post-reset empty", int'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sfpp_reconfig_master_0_rx_fifo_adt.md
Name: sfpp_reconfig_master_0_rx_fifo_adt

Overview:
Avalon-ST byte-stream timing adapter for the reconfig master's link. It places a buffer between an upstream source that cannot be backpressured (no ready) and a downstream sink that can deassert ready. Instead of only warning on backpressure, it absorbs bursts in a FIFO. On overflow it drops the byte and records the loss in a sticky flag and a saturating drop counter. It also reports fill level and almost-full status so upstream control logic can throttle at packet granularity.

Parameters:
DATA_WIDTH, 8, payload width in bits.
DEPTH, 16, FIFO entries; power of 2, at least 2.
ALMOST_FULL, 12, fill_level at or above this value asserts almost_full; range 1..DEPTH.
DROP_CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
clk  in  1  single clock domain.
reset_n  in  1  asynchronous, active-low reset.
in_valid  in  1  upstream byte valid; there is no in_ready.
in_data  in  DATA_WIDTH  upstream payload.
out_valid  out  1  downstream byte valid.
out_data  out  DATA_WIDTH  downstream payload.
out_ready  in  1  downstream ready, ready latency 0.
fill_level  out  log2(DEPTH)+1  current entry count, 0..DEPTH.
almost_full  out  1  fill_level >= ALMOST_FULL.
overflow  out  1  sticky: at least one byte was dropped.
drop_count  out  DROP_CNT_WIDTH  bytes dropped; saturates at all-ones.
clear_overflow  in  1  synchronous clear of overflow and drop_count.

Behaviour:
- Reset (asynchronous assert, synchronous release): read/write pointers = 0, fill_level = 0, out_valid = 0, almost_full = 0, overflow = 0, drop_count = 0. FIFO storage is not reset.
- push = in_valid & (not full | pop).
- pop = out_valid & out_ready.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from fill_level, not from pointer compare alone.
- Show-ahead read:
  - out_valid = (fill_level != 0), registered.
  - out_data = storage[rd_ptr]; stable while out_valid=1 and out_ready=0.
  - out_data is don't-care while out_valid=0 and must not be checked.
- Latency: a byte pushed at edge N is visible on out_valid/out_data after edge N, i.e. in cycle N+1. There is no combinational in-to-out bypass; empty plus in_valid gives out_valid=0 in that same cycle.
- Ordering: strict FIFO; bytes are never reordered or duplicated.
- fill_level update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Full with pop in the same cycle: the incoming byte is accepted and fill stays at DEPTH. No drop occurs.
- Full without pop and in_valid=1: the byte is discarded, overflow is set to 1, and drop_count increments unless it is already all-ones.
- clear_overflow=1 clears overflow and drop_count at the next edge. A drop in the same cycle takes effect after the clear: overflow=1, drop_count=1.
- almost_full is registered and consistent with the registered fill_level (same-cycle view).
- out_ready while empty has no effect. There is no underflow, and pointers do not move.
- Reset asserted mid-stream: all buffered bytes are lost and outputs return to reset values immediately (asynchronous). The first byte after release has latency 1 as above.
- Simulation-only check (excluded from synthesis): display a message on every dropped byte.

Test Plan:
- Reset, then push 0x01..0x05 on consecutive cycles with out_ready=1 -> out_data sequence 0x01..0x05, each one cycle after input. fill_level never exceeds 1. overflow=0.
- out_ready=0, push 16 bytes 0x10..0x1F -> fill_level=16, almost_full asserted in the cycle after the 12th push, overflow=0. Then set out_ready=1 -> 0x10..0x1F drained in order, out_valid drops after the 16th byte.
- Full FIFO with out_ready=0, push 3 more bytes -> overflow=1, drop_count=3, contents still 0x10..0x1F. Assert clear_overflow for one cycle -> overflow=0, drop_count=0.
- Full FIFO with out_ready=1 and in_valid=1 for 10 cycles -> no drops, fill_level stays 16, output order preserved across pointer wrap.
- 300 drops with DROP_CNT_WIDTH=8 -> drop_count saturates at 0xFF. A drop coinciding with clear_overflow -> drop_count=1, overflow=1.
- Assert reset_n low mid-burst with fill_level=7 -> out_valid=0 and fill_level=0 immediately. After release, push 0xAA -> 0xAA is the next output byte with no stale data.
